// File: rtl/ring_interlock_pkg.sv
// Shared definitions for the ring interlock requester: state encoding, ring size and
// default cycle counts.
package ring_interlock_pkg;

   localparam int unsigned NODE_COUNT = 8;

   localparam int unsigned DEF_CONFIRM_CYCLES = 4;
   localparam int unsigned DEF_DWELL_CYCLES   = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
   localparam int unsigned DEF_HOLDOFF_CYCLES = 8;
   localparam int unsigned DEF_CNT_W          = 8;

   // Encoding is visible on o_State, so the values are fixed.
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReq     = 3'd1,
      StActive  = 3'd2,
      StRelease = 3'd3,
      StFault   = 3'd4
   } state_e;

endpackage

// File: rtl/interlock_cycle_timer.sv
// Saturating up-counter with synchronous clear and a terminal-value compare.
module interlock_cycle_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             term_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Clear wins over count; hold at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign term_o = (count_q == term_i);

endmodule

// File: rtl/ring_interlock_requester.sv
// Node-side requester for the ring interlock: raises the node request, confirms the grant,
// runs a timed actuator enable, and enforces an off-time after each release. Grant timeout
// or loss of grant while enabled latches a fault until cleared.
module ring_interlock_requester
   import ring_interlock_pkg::*;
#(
   parameter int unsigned CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
   parameter int unsigned DWELL_CYCLES   = DEF_DWELL_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Cmd,
   input  logic       i_Abort,
   input  logic       i_Clear,
   input  logic       i_Grant,
   output logic       o_Req,
   output logic       o_Enable,
   output logic       o_Busy,
   output logic       o_Done,
   output logic       o_Fault,
   output logic [2:0] o_State
);

   // Terminal values are "last cycle in state" indices since the counters start at 0.
   localparam logic [CNT_W-1:0] ConfirmTerm = CNT_W'(CONFIRM_CYCLES - 1);
   localparam logic [CNT_W-1:0] DwellTerm   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutTerm = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldoffTerm = CNT_W'(HOLDOFF_CYCLES - 1);

   if ((CONFIRM_CYCLES < 1) || (DWELL_CYCLES < 1) || (HOLDOFF_CYCLES < 1) ||
       (TIMEOUT_CYCLES <= CONFIRM_CYCLES)) begin : g_bad_cycles
      $error("ring_interlock_requester: illegal cycle parameters");
   end
   if ((CNT_W > 31) || (TIMEOUT_CYCLES > (1 << CNT_W)) || (DWELL_CYCLES > (1 << CNT_W)) ||
       (HOLDOFF_CYCLES > (1 << CNT_W))) begin : g_bad_width
      $error("ring_interlock_requester: CNT_W too narrow for cycle parameters");
   end

   state_e           state_q, state_d;
   logic             state_chg;
   logic             tmr_en, tmr_term;
   logic [CNT_W-1:0] tmr_term_val;
   logic             run_clr, run_en, run_term;
   logic             confirm;

   logic req_q, req_d;
   logic enable_q, enable_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic fault_q, fault_d;

   assign state_chg = (state_d != state_q);

   // Full run of consecutive grants including the current cycle.
   assign confirm = i_Grant && run_term;

   // State timer: cleared on every state entry, counts only in timed states.
   assign tmr_en = (state_q == StReq) || (state_q == StActive) || (state_q == StRelease);

   // Select which limit the state timer is compared against.
   always_comb begin
      tmr_term_val = '0;
      case (state_q)
         StReq:     tmr_term_val = TimeoutTerm;
         StActive:  tmr_term_val = DwellTerm;
         StRelease: tmr_term_val = HoldoffTerm;
         default:   tmr_term_val = '0;
      endcase
   end

   interlock_cycle_timer #(
      .CNT_W (CNT_W)
   ) u_state_timer (
      .clk_i  (i_Clk),
      .rst_ni (i_Rst_n),
      .clr_i  (state_chg),
      .en_i   (tmr_en),
      .term_i (tmr_term_val),
      .term_o (tmr_term)
   );

   // Grant run counter only means anything in REQ; any low grant restarts the run.
   assign run_en  = (state_q == StReq) && i_Grant;
   assign run_clr = state_chg || ((state_q == StReq) && !i_Grant);

   interlock_cycle_timer #(
      .CNT_W (CNT_W)
   ) u_confirm_run (
      .clk_i  (i_Clk),
      .rst_ni (i_Rst_n),
      .clr_i  (run_clr),
      .en_i   (run_en),
      .term_i (ConfirmTerm),
      .term_o (run_term)
   );

   // Next-state logic; priorities follow the interlock safety ordering.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_Cmd) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (i_Abort || !i_Cmd) begin
               state_d = StRelease;
            end else if (confirm) begin
               state_d = StActive;
            end else if (tmr_term) begin
               state_d = StFault;
            end
         end
         StActive: begin
            // Grant loss is a safety event and outranks abort and completion.
            if (!i_Grant) begin
               state_d = StFault;
            end else if (i_Abort) begin
               state_d = StRelease;
            end else if (tmr_term) begin
               state_d = StRelease;
               done_d  = 1'b1;
            end
         end
         StRelease: begin
            if (tmr_term) begin
               state_d = StIdle;
            end
         end
         StFault: begin
            if (i_Clear) begin
               state_d = StRelease;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      req_d    = (state_d == StReq) || (state_d == StActive);
      enable_d = (state_d == StActive);
      busy_d   = (state_d != StIdle);
      fault_d  = (state_d == StFault);
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   assign o_Req    = req_q;
   assign o_Enable = enable_q;
   assign o_Busy   = busy_q;
   assign o_Done   = done_q;
   assign o_Fault  = fault_q;
   assign o_State  = state_q;

endmodule

// File: tb/tb_ring_interlock_requester.sv
// Bench for ring_interlock_requester: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural model of the requester.
module tb_ring_interlock_requester;

   localparam int unsigned Confirm = 4;
   localparam int unsigned Dwell   = 16;
   localparam int unsigned Timeout = 64;
   localparam int unsigned Holdoff = 8;
   localparam int unsigned CntW    = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd = 1'b0;
   logic       abort_in = 1'b0;
   logic       clr = 1'b0;
   logic       grant = 1'b0;
   logic       req, en, busy, done, fault;
   logic [2:0] st;

   always #5 clk = ~clk;

   ring_interlock_requester #(
      .CONFIRM_CYCLES (Confirm),
      .DWELL_CYCLES   (Dwell),
      .TIMEOUT_CYCLES (Timeout),
      .HOLDOFF_CYCLES (Holdoff),
      .CNT_W          (CntW)
   ) dut (
      .i_Clk    (clk),
      .i_Rst_n  (rst_n),
      .i_Cmd    (cmd),
      .i_Abort  (abort_in),
      .i_Clear  (clr),
      .i_Grant  (grant),
      .o_Req    (req),
      .o_Enable (en),
      .o_Busy   (busy),
      .o_Done   (done),
      .o_Fault  (fault),
      .o_State  (st)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: phase name as integer, cycles already spent in it, current grant run length.
   int m_phase = 0;
   int m_age   = 0;
   int m_run   = 0;
   bit m_done  = 1'b0;

   int en_cnt, done_cnt, rel_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the reference behaviour, using the inputs seen at that edge.
   task automatic model_step(input bit c, input bit a, input bit cl, input bit g, input bit r);
      int nxt;
      int run_now;
      if (!r) begin
         m_phase = 0;
         m_age   = 0;
         m_run   = 0;
         m_done  = 1'b0;
         return;
      end
      nxt     = m_phase;
      m_done  = 1'b0;
      run_now = g ? m_run + 1 : 0;
      case (m_phase)
         0: if (c) nxt = 1;
         1: begin
            if (a || !c) nxt = 3;
            else if (run_now >= Confirm) nxt = 2;
            else if (m_age + 1 >= Timeout) nxt = 4;
         end
         2: begin
            if (!g) nxt = 4;
            else if (a) nxt = 3;
            else if (m_age + 1 >= Dwell) begin
               nxt    = 3;
               m_done = 1'b1;
            end
         end
         3: if (m_age + 1 >= Holdoff) nxt = 0;
         default: if (cl) nxt = 3;
      endcase
      if (nxt != m_phase) begin
         m_phase = nxt;
         m_age   = 0;
         m_run   = 0;
      end else begin
         m_age++;
         m_run = (m_phase == 1) ? run_now : 0;
      end
   endtask

   task automatic tick();
      bit c, a, cl, g, r;
      c = cmd; a = abort_in; cl = clr; g = grant; r = rst_n;
      @(posedge clk);
      model_step(c, a, cl, g, r);
      #1;
      check_eq("o_State", 32'(st), m_phase);
      check_eq("o_Req", 32'(req), 32'((m_phase == 1) || (m_phase == 2)));
      check_eq("o_Enable", 32'(en), 32'(m_phase == 2));
      check_eq("o_Busy", 32'(busy), 32'(m_phase != 0));
      check_eq("o_Done", 32'(done), 32'(m_done));
      check_eq("o_Fault", 32'(fault), 32'(m_phase == 4));
      if (en === 1'b1) en_cnt++;
      if (done === 1'b1) done_cnt++;
      if (st === 3'd3) rel_cnt++;
   endtask

   task automatic clear_counts();
      en_cnt = 0;
      done_cnt = 0;
      rel_cnt = 0;
   endtask

   function automatic bit cond_met(input int code);
      case (code)
         0:       return en === 1'b1;
         1:       return fault === 1'b1;
         default: return st === 3'd0;
      endcase
   endfunction

   // Ticks until the condition holds or the limit expires; n is the tick count.
   task automatic run_until(input int code, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!cond_met(code) && n < limit);
   endtask

   initial begin
      int n;
      bit pat [8];
      int grant_pct, cmd_pct;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      clear_counts();

      // Reset
      rst_n = 1'b0;
      repeat (3) tick();
      check_eq("reset_state", 32'(st), 0);
      rst_n = 1'b1;
      tick();

      // Normal operation
      grant = 1'b1;
      cmd = 1'b1;
      tick();
      check_eq("req_rise", 32'(req), 1);
      clear_counts();
      run_until(0, 100, n);
      check_eq("confirm_latency", n, Confirm);
      cmd = 1'b0;
      run_until(2, 200, n);
      check_eq("enable_width", en_cnt, Dwell);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("holdoff_len", rel_cnt, Holdoff);

      // Confirm glitch
      cmd = 1'b1;
      tick();
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         grant = pat[i];
         tick();
      end
      check_eq("glitch_enable_now", 32'(en), 1);
      check_eq("glitch_enable_late", en_cnt, 1);
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      cmd = 1'b0;
      run_until(2, 200, n);
      check_eq("glitch_no_done", done_cnt, 0);

      // Timeout
      grant = 1'b0;
      cmd = 1'b1;
      tick();
      run_until(1, 200, n);
      check_eq("timeout_latency", n, Timeout);
      check_eq("timeout_req_low", 32'(req), 0);
      clear_counts();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      run_until(2, 200, n);
      check_eq("clear_holdoff", n, Holdoff);
      check_eq("clear_release_cycles", rel_cnt, Holdoff);
      tick();
      check_eq("rereq_after_clear", 32'(st), 1);
      cmd = 1'b0;
      grant = 1'b1;
      run_until(2, 200, n);

      // Grant loss at dwell cycle 5
      cmd = 1'b1;
      tick();
      clear_counts();
      run_until(0, 100, n);
      repeat (5) tick();
      grant = 1'b0;
      tick();
      check_eq("loss_enable", 32'(en), 0);
      check_eq("loss_fault", 32'(fault), 1);
      check_eq("loss_no_done", done_cnt, 0);
      grant = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      cmd = 1'b0;
      run_until(2, 200, n);

      // Abort on the confirming cycle
      cmd = 1'b1;
      tick();
      clear_counts();
      repeat (Confirm - 1) tick();
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      cmd = 1'b0;
      check_eq("abort_to_release", 32'(st), 3);
      run_until(2, 200, n);
      check_eq("abort_no_enable", en_cnt, 0);

      // Reset while active
      cmd = 1'b1;
      tick();
      run_until(0, 100, n);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check_eq("rst_enable", 32'(en), 0);
      check_eq("rst_req", 32'(req), 0);
      check_eq("rst_state", 32'(st), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      cmd = 1'b0;
      tick();

      // Random traffic with per-chunk biases
      for (int chunk = 0; chunk < 16; chunk++) begin
         case ($urandom_range(0, 2))
            0:       grant_pct = 50;
            1:       grant_pct = 90;
            default: grant_pct = 100;
         endcase
         cmd_pct = ($urandom_range(0, 1) == 0) ? 80 : 99;
         for (int i = 0; i < 200; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            cmd      = ($urandom_range(0, 99) < cmd_pct);
            abort_in = ($urandom_range(0, 59) == 0);
            clr      = ($urandom_range(0, 7) == 0);
            grant    = ($urandom_range(0, 99) < grant_pct);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
